// File: rtl/liteeth_sram_fifo_pkg.sv
// rtl/liteeth_sram_fifo_pkg.sv - shared sizes and types for the SRAM-backed streaming FIFO
package liteeth_sram_fifo_pkg;
    localparam int BITS       = 64;
    localparam int WORD_DEPTH = 1024;
    localparam int ADDR_WIDTH = 10;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [BITS-1:0]       word_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(WORD_DEPTH);
endpackage

// File: rtl/liteeth_sram_fifo_outbuf.sv
// rtl/liteeth_sram_fifo_outbuf.sv - 2-entry prefetch buffer absorbing the SRAM read latency
module liteeth_sram_fifo_outbuf
    import liteeth_sram_fifo_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push_vld,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    output logic [1:0]      cnt,
    output logic            head_vld,
    output logic [BITS-1:0] head_data
);
    word_t slot0;
    word_t slot1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else begin
            // Pop is applied before the push so arrival order is preserved.
            case ({pop, push_vld})
                2'b01: begin
                    if (cnt == 2'd0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b10: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_vld  = (cnt != 2'd0);
    assign head_data = slot0;
endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// rtl/liteeth_sram_fifo_ctrl.sv - FWFT FIFO over a 1RW+1R SRAM macro; LITEETH_SRAM_FIFO_LEVEL_EN adds a level port
module liteeth_sram_fifo_ctrl
    import liteeth_sram_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_data,
    output logic                  sram_rw0_ce,
    output logic                  sram_rw0_we,
    output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
    output logic [BITS-1:0]       sram_rw0_wd,
    input  logic [BITS-1:0]       sram_rw0_rd,
    output logic                  sram_r0_ce,
    output logic [ADDR_WIDTH-1:0] sram_r0_addr,
    input  logic [BITS-1:0]       sram_r0_rd
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level
`endif
);
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    cnt_t       mem_cnt;
    logic       inflight;
    logic [1:0] ob_cnt;
    logic [2:0] ob_occ;
    logic       push;
    logic       pop;
    logic       rd_issue;
    logic       unused_rw0_rd;

    assign unused_rw0_rd = ^sram_rw0_rd;

    assign in_ready = (mem_cnt != DEPTH_CNT) & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Only issue a read if the buffer will have room for it when the data returns.
    assign ob_occ   = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_issue = (mem_cnt != '0) & ~flush & (ob_occ <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_issue) rd_ptr <= rd_ptr + ptr_t'(1);
            if (push && !rd_issue)      mem_cnt <= mem_cnt + cnt_t'(1);
            else if (!push && rd_issue) mem_cnt <= mem_cnt - cnt_t'(1);
            inflight <= rd_issue;
        end
    end

    liteeth_sram_fifo_outbuf u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push_vld  (inflight),
        .push_data (sram_r0_rd),
        .pop       (pop),
        .cnt       (ob_cnt),
        .head_vld  (out_valid),
        .head_data (out_data)
    );

    assign sram_rw0_ce   = push;
    assign sram_rw0_we   = push;
    assign sram_rw0_addr = wr_ptr;
    assign sram_rw0_wd   = in_data;
    assign sram_r0_ce    = rd_issue;
    assign sram_r0_addr  = rd_ptr;

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    typedef logic [ADDR_WIDTH+1:0] level_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     level <= '0;
        else if (flush) level <= '0;
        else            level <= level_t'(mem_cnt) + level_t'(inflight) + level_t'(ob_cnt);
    end
`endif
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb/tb_liteeth_sram_fifo_ctrl.sv - self-checking bench for liteeth_sram_fifo_ctrl
module tb_liteeth_sram_fifo_ctrl;
    import liteeth_sram_fifo_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [BITS-1:0]       in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BITS-1:0]       out_data;
    logic                  sram_rw0_ce;
    logic                  sram_rw0_we;
    logic [ADDR_WIDTH-1:0] sram_rw0_addr;
    logic [BITS-1:0]       sram_rw0_wd;
    logic                  sram_r0_ce;
    logic [ADDR_WIDTH-1:0] sram_r0_addr;
    logic [BITS-1:0]       r0_q;
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] level;
`endif

    always #5 clk = ~clk;

    // Behavioural 1RW+1R macro: synchronous write, one-cycle registered read.
    logic [BITS-1:0] mem [0:WORD_DEPTH-1];
    always @(posedge clk) begin
        if (sram_rw0_ce && sram_rw0_we) mem[sram_rw0_addr] <= sram_rw0_wd;
        if (sram_r0_ce) r0_q <= mem[sram_r0_addr];
    end

    liteeth_sram_fifo_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .sram_rw0_ce   (sram_rw0_ce),
        .sram_rw0_we   (sram_rw0_we),
        .sram_rw0_addr (sram_rw0_addr),
        .sram_rw0_wd   (sram_rw0_wd),
        .sram_rw0_rd   ('0),
        .sram_r0_ce    (sram_r0_ce),
        .sram_r0_addr  (sram_r0_addr),
        .sram_r0_rd    (r0_q)
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        ,
        .level         (level)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        e_in_ready;
        logic        e_wce;
        logic        e_rce;
        logic [9:0]  e_raddr;
        logic        e_ov;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs [5];

    logic [63:0] sb_q [$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int pushed;
        int popped;
        int bubbles;
        int collisions;
        int seen;
        bit started;
        bit got;
        logic [63:0] exp_word;

        // First-word latency: accept at cycle 0, read issue at 1, head valid at 3.
        vecs[0] = '{1'b1, 64'hDEADBEEF00000001, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 64'd0};
        vecs[1] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 64'd0};
        vecs[2] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 64'd0};
        vecs[3] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 64'hDEADBEEF00000001};
        vecs[4] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 64'd0};

        do_reset();
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_rw0_ce", 64'(sram_rw0_ce), 64'd0);
        check("reset_rw0_we", 64'(sram_rw0_we), 64'd0);
        check("reset_r0_ce", 64'(sram_r0_ce), 64'd0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        check("reset_level", 64'(level), 64'd0);
`endif

        for (int i = 0; i < 5; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("lat%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_in_ready));
            check($sformatf("lat%0d_rw0_ce", i), 64'(sram_rw0_ce), 64'(vecs[i].e_wce));
            check($sformatf("lat%0d_r0_ce", i), 64'(sram_r0_ce), 64'(vecs[i].e_rce));
            if (vecs[i].e_rce)
                check($sformatf("lat%0d_r0_addr", i), 64'(sram_r0_addr), 64'(vecs[i].e_raddr));
            check($sformatf("lat%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check($sformatf("lat%0d_out_data", i), out_data, vecs[i].e_od);
            tick();
        end

        // Capacity: macro plus the two prefetch slots.
        do_reset();
        accepts = 0;
        for (int c = 0; c < 1100; c++) begin
            in_valid = 1'b1;
            in_data  = 64'(accepts);
            #1;
            if (in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("cap_accepts", 64'(accepts), 64'd1026);
        check("cap_in_ready_full", 64'(in_ready), 64'd0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        check("cap_level_full", 64'(level), 64'd1026);
`endif
        out_ready = 1'b1;
        #1;
        check("cap_pop_valid", 64'(out_valid), 64'd1);
        check("cap_pop_data", out_data, 64'd0);
        tick();
        out_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2 && !got; c++) begin
            #1;
            if (in_ready) got = 1'b1;
            else tick();
        end
        check("cap_in_ready_after_pop", 64'(got), 64'd1);

        // Full-rate streaming across the pointer wrap.
        do_reset();
        pushed = 0; popped = 0; bubbles = 0; started = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3200 && popped < 3000; c++) begin
            in_valid = (pushed < 3000);
            in_data  = 64'(pushed);
            #1;
            if (in_valid && in_ready) pushed++;
            if (out_valid) begin
                started = 1'b1;
                if (out_data !== 64'(popped))
                    check("stream_data", out_data, 64'(popped));
                popped++;
            end else if (started) begin
                bubbles++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_pushed", 64'(pushed), 64'd3000);
        check("stream_popped", 64'(popped), 64'd3000);
        check("stream_bubbles", 64'(bubbles), 64'd0);

        // Random traffic against an ordered scoreboard.
        do_reset();
        sb_q.delete();
        collisions = 0;
        for (int c = 0; c < 20000; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = {$urandom, $urandom};
            #1;
            if (sram_rw0_ce && sram_r0_ce && (sram_rw0_addr == sram_r0_addr)) collisions++;
            if (sb_q.size() < WORD_DEPTH)
                check("rand_in_ready", 64'(in_ready), 64'd1);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rand_pop_nonempty", 64'd0, 64'd1);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("rand_data", out_data, exp_word);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand_no_collision", 64'(collisions), 64'd0);

        // Flush while a read is in flight; stale read data must not reappear.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        #1;
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        check("flush_pre_issue", 64'(sram_r0_ce), 64'd1);
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_r0_ce", 64'(sram_r0_ce), 64'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        out_ready = 1'b1;
        #1;
        check("post_flush_out_valid", 64'(out_valid), 64'd0);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            if (out_valid) begin
                got = 1'b1;
                check("post_flush_first", out_data, 64'hA5);
            end
            tick();
        end
        check("post_flush_got_word", 64'(got), 64'd1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("post_flush_no_stale", 64'(seen), 64'd0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 64'(c + 7);
            tick();
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", out_data, 64'd0);
        check("async_rw0_ce", 64'(sram_rw0_ce), 64'd0);
        check("async_rw0_we", 64'(sram_rw0_we), 64'd0);
        check("async_r0_ce", 64'(sram_r0_ce), 64'd0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        check("async_level", 64'(level), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
